sync_fifo_lvl: RTL and testbench

Parametrised synchronous FIFO, successor to the 8-bit UART byte FIFO. Generalised data width and depth, occupancy count, programmable almost-full/almost-empty watermarks, synchronous flush, and simultaneous read/write at the full and empty boundaries. It sits between the UART RX/TX shift engines and the debug-transport logic, and is reusable wherever a single-clock buffer is needed.

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/fifo_ram.sv | 34 +++
 rtl/sync_fifo_lvl.sv | 123 ++++++++++++
 tb/tb_sync_fifo_lvl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg
// Shared widths helper and registered status bundle for sync_fifo_lvl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Widest level field carried in the status bundle; bounds ABITS to 15.
  localparam int unsigned LVL_W = 16;

  typedef struct packed {
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LVL_W-1:0] level;
  } status_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic status_t make_status(input logic [LVL_W-1:0] cnt,
                                          input int unsigned      depth,
                                          input int unsigned      af,
                                          input int unsigned      ae);
    status_t s;
    s.level        = cnt;
    s.full         = (32'(cnt) == depth);
    s.empty        = (cnt == '0);
    s.almost_full  = (32'(cnt) >= af);
    s.almost_empty = (32'(cnt) <= ae);
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// fifo_ram
// Storage array: one write port, one asynchronous read port, no reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_ram #(
  parameter int unsigned ABITS = 4,
  parameter int unsigned DBITS = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] wdata_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [DBITS-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_lvl.sv
// ============================================================================
// sync_fifo_lvl
// Single-clock show-ahead FIFO with level, watermarks, flush and error flags.
// Optional: FIFO_ERR_FLAGS_EN enables sticky OVERFLOW_O / UNDERFLOW_O.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned ABITS     = 4,
  parameter int unsigned DBITS     = 8,
  parameter int unsigned AF_THRESH = 2 ** ABITS - 1,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic             CLK_I,
  input  logic             RST_NI,
  input  logic             CLEAR_I,
  input  logic             WE_I,
  input  logic [DBITS-1:0] W_DATA_I,
  input  logic             RE_I,
  output logic [DBITS-1:0] R_DATA_O,
  output logic             FULL_O,
  output logic             EMPTY_O,
  output logic             ALMOST_FULL_O,
  output logic             ALMOST_EMPTY_O,
  output logic [ABITS:0]   LEVEL_O,
  output logic             OVERFLOW_O,
  output logic             UNDERFLOW_O
);

  localparam int unsigned DEPTH = 2 ** ABITS;
  localparam int unsigned CW    = cnt_width(DEPTH);

  logic [ABITS-1:0] wptr_q, wptr_d;
  logic [ABITS-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count, count_d;
  status_t          status_q, status_d;
  logic             push, pop;
  logic             unused_lvl_hi;

  // The registered status bundle doubles as the count register.
  assign count         = status_q.level[CW-1:0];
  assign unused_lvl_hi = ^status_q.level;

  assign pop  = RE_I & ~status_q.empty;
  assign push = WE_I & (~status_q.full | RE_I);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count;
    if (CLEAR_I) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count + 1'b1;
      else if (pop && !push) count_d = count - 1'b1;
    end
  end

  assign status_d = make_status(LVL_W'(count_d), DEPTH, AF_THRESH, AE_THRESH);

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      status_q <= make_status('0, DEPTH, AF_THRESH, AE_THRESH);
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      status_q <= status_d;
    end
  end

  fifo_ram #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_ram (
    .clk_i   (CLK_I),
    .we_i    (push & ~CLEAR_I),
    .waddr_i (wptr_q),
    .wdata_i (W_DATA_I),
    .raddr_i (rptr_q),
    .rdata_o (R_DATA_O)
  );

  assign FULL_O         = status_q.full;
  assign EMPTY_O        = status_q.empty;
  assign ALMOST_FULL_O  = status_q.almost_full;
  assign ALMOST_EMPTY_O = status_q.almost_empty;
  assign LEVEL_O        = count;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (CLEAR_I) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WE_I && !push) ovf_q <= 1'b1;
      if (RE_I && !pop)  udf_q <= 1'b1;
    end
  end

  assign OVERFLOW_O  = ovf_q;
  assign UNDERFLOW_O = udf_q;
`else
  assign OVERFLOW_O  = 1'b0;
  assign UNDERFLOW_O = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
// ============================================================================
// tb_sync_fifo_lvl
// Directed and random stimulus against a queue-based reference of the FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_lvl;

  localparam int ABITS = 2;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             CLK_I = 1'b0;
  logic             RST_NI;
  logic             CLEAR_I;
  logic             WE_I;
  logic [DBITS-1:0] W_DATA_I;
  logic             RE_I;
  logic [DBITS-1:0] R_DATA_O;
  logic             FULL_O;
  logic             EMPTY_O;
  logic             ALMOST_FULL_O;
  logic             ALMOST_EMPTY_O;
  logic [ABITS:0]   LEVEL_O;
  logic             OVERFLOW_O;
  logic             UNDERFLOW_O;

  sync_fifo_lvl #(
    .ABITS     (ABITS),
    .DBITS     (DBITS),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .CLK_I          (CLK_I),
    .RST_NI         (RST_NI),
    .CLEAR_I        (CLEAR_I),
    .WE_I           (WE_I),
    .W_DATA_I       (W_DATA_I),
    .RE_I           (RE_I),
    .R_DATA_O       (R_DATA_O),
    .FULL_O         (FULL_O),
    .EMPTY_O        (EMPTY_O),
    .ALMOST_FULL_O  (ALMOST_FULL_O),
    .ALMOST_EMPTY_O (ALMOST_EMPTY_O),
    .LEVEL_O        (LEVEL_O),
    .OVERFLOW_O     (OVERFLOW_O),
    .UNDERFLOW_O    (UNDERFLOW_O)
  );

  always #5 CLK_I = ~CLK_I;

  logic [DBITS-1:0] mq[$];
  bit               m_ovf;
  bit               m_udf;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = mq.size();
    check({ctx, ".level"},  32'(LEVEL_O),        32'(n));
    check({ctx, ".empty"},  32'(EMPTY_O),        32'(n == 0));
    check({ctx, ".full"},   32'(FULL_O),         32'(n == DEPTH));
    check({ctx, ".afull"},  32'(ALMOST_FULL_O),  32'(n >= AF));
    check({ctx, ".aempty"}, 32'(ALMOST_EMPTY_O), 32'(n <= AE));
    if (n > 0) check({ctx, ".rdata"}, 32'(R_DATA_O), 32'(mq[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check({ctx, ".ovf"}, 32'(OVERFLOW_O),  32'(m_ovf));
    check({ctx, ".udf"}, 32'(UNDERFLOW_O), 32'(m_udf));
`else
    check({ctx, ".ovf"}, 32'(OVERFLOW_O),  32'd0);
    check({ctx, ".udf"}, 32'(UNDERFLOW_O), 32'd0);
`endif
  endtask

  // One clock of stimulus; reference queue updated from the push/pop rules.
  task automatic step(input bit we, input bit re, input bit clr,
                      input logic [DBITS-1:0] d, input string ctx);
    bit pop_ok;
    bit push_ok;
    WE_I     = we;
    RE_I     = re;
    CLEAR_I  = clr;
    W_DATA_I = d;
    @(posedge CLK_I);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pop_ok  = re && (mq.size() > 0);
      push_ok = we && ((mq.size() < DEPTH) || pop_ok);
      if (we && !push_ok) m_ovf = 1'b1;
      if (re && !pop_ok)  m_udf = 1'b1;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [DBITS-1:0] pat [4];
    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    RST_NI   = 1'b1;
    CLEAR_I  = 1'b0;
    WE_I     = 1'b0;
    RE_I     = 1'b0;
    W_DATA_I = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;

    #1 RST_NI = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1 check_all("reset");
    @(negedge CLK_I) RST_NI = 1'b1;
    step(0, 0, 0, 8'h00, "idle");

    foreach (pat[i]) step(1, 0, 0, pat[i], "fill");
    repeat (4) step(0, 1, 0, 8'h00, "drain");

    step(1, 0, 0, 8'h11, "refill");
    step(1, 0, 0, 8'h22, "refill");
    step(1, 0, 0, 8'h33, "refill");
    step(1, 0, 0, 8'h44, "refill");
    repeat (4) step(1, 1, 0, 8'hE5, "full_rw");
    repeat (4) step(0, 1, 0, 8'h00, "wrap_drain");

    step(1, 1, 0, 8'h55, "empty_rw");
    step(0, 1, 0, 8'h00, "empty_rw_pop");

    step(0, 0, 1, 8'h00, "clear0");
    foreach (pat[i]) step(1, 0, 0, pat[i] ^ 8'hFF, "fill2");
    step(1, 0, 0, 8'h99, "full_we");
    step(0, 0, 1, 8'h00, "clear1");
    step(1, 1, 1, 8'h77, "clear_rw");

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, 8'($urandom), "rand");
    end

    step(0, 0, 1, 8'h00, "pre_rst");
    step(1, 0, 0, 8'h3C, "pre_rst");
    step(1, 0, 0, 8'h5A, "pre_rst");
    WE_I = 1'b1;
    W_DATA_I = 8'h66;
    #2 RST_NI = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1 check_all("async_rst");
    WE_I = 1'b0;
    #2 RST_NI = 1'b1;
    step(1, 0, 0, 8'h81, "post_rst");
    step(0, 1, 0, 8'h00, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
